// File: rtl/dma_mem_responder.sv
// Burst read/write responder over a single-port word array; one burst in service at a time.
// Read beat 1 cycle after accept, held while rd_ready=0; writes accepted from the cycle after accept. Option macro: DMA_MEM_RESP_ERR_EN.
module dma_mem_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           rd_req_addr,
    input  logic [4:0]            rd_req_len,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    input  logic [31:0]           wr_req_addr,
    input  logic [4:0]            wr_req_len,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
`ifdef DMA_MEM_RESP_ERR_EN
    input  logic                  wr_last,
    output logic                  err
`else
    input  logic                  wr_last
`endif
);

    localparam int IW    = MEM_ADDR_WIDTH;
    localparam int DEPTH = 1 << IW;
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]         r_idx;
    logic [4:0]            r_cnt;
    logic [4:0]            r_len;
    logic                  r_favour_wr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic                  r_wr_ready;

    logic          w_idle;
    logic          w_rd_grant;
    logic          w_wr_grant;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic [IW-1:0] w_rd_idx;
    logic [IW-1:0] w_wr_idx;
    logic          w_wr_beat;
    logic          w_cnt_done;
    logic          w_unused;

    // With both requests pending, the channel not served last wins.
    assign w_idle     = (r_state == IDLE);
    assign w_rd_grant = rd_req_valid && (!wr_req_valid || !r_favour_wr);
    assign w_wr_grant = wr_req_valid && (!rd_req_valid ||  r_favour_wr);
    assign w_rd_acc   = w_idle && w_rd_grant;
    assign w_wr_acc   = w_idle && w_wr_grant;
    assign w_rd_idx   = rd_req_addr[IW+1:2];
    assign w_wr_idx   = wr_req_addr[IW+1:2];
    assign w_wr_beat  = (r_state == WR_BURST) && wr_valid;
    assign w_cnt_done = (r_cnt == r_len);

    assign rd_req_ready = w_rd_acc;
    assign wr_req_ready = w_wr_acc;
    assign rd_rdata     = r_rdata;
    assign rd_valid     = r_rd_valid;
    assign rd_last      = r_rd_last;
    assign wr_ready     = r_wr_ready;

    // Array is never reset; a reset mid-write keeps the beats already stored.
    always_ff @(posedge clk) begin
        if (w_wr_beat) begin
            r_mem[r_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_favour_wr <= 1'b0;
            r_rdata     <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_wr_ready  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rd_acc) begin
                        r_state     <= RD_BURST;
                        r_rdata     <= r_mem[w_rd_idx];
                        r_idx       <= w_rd_idx + IDX_ONE;
                        r_cnt       <= '0;
                        r_len       <= rd_req_len;
                        r_rd_valid  <= 1'b1;
                        r_rd_last   <= (rd_req_len == 5'd0);
                        r_favour_wr <= 1'b1;
                    end else if (w_wr_acc) begin
                        r_state     <= WR_BURST;
                        r_idx       <= w_wr_idx;
                        r_cnt       <= '0;
                        r_len       <= wr_req_len;
                        r_wr_ready  <= 1'b1;
                        r_favour_wr <= 1'b0;
                    end
                end
                RD_BURST: begin
                    // r_idx already points at the word after the one on rd_rdata.
                    if (rd_ready) begin
                        if (w_cnt_done) begin
                            r_state    <= IDLE;
                            r_rd_valid <= 1'b0;
                            r_rd_last  <= 1'b0;
                        end else begin
                            r_rdata   <= r_mem[r_idx];
                            r_idx     <= r_idx + IDX_ONE;
                            r_cnt     <= r_cnt + 5'd1;
                            r_rd_last <= ((r_cnt + 5'd1) == r_len);
                        end
                    end
                end
                WR_BURST: begin
                    if (wr_valid) begin
                        r_idx <= r_idx + IDX_ONE;
                        r_cnt <= r_cnt + 5'd1;
                        if (w_cnt_done) begin
                            r_state    <= IDLE;
                            r_wr_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMA_MEM_RESP_ERR_EN
    logic [IW:0] w_rd_end;
    logic [IW:0] w_wr_end;
    logic        w_rd_bad;
    logic        w_wr_bad;
    logic        w_beat_bad;
    logic        r_err;

    // Last index of the burst; a carry into bit IW means the index wraps.
    assign w_rd_end   = {1'b0, w_rd_idx} + (IW+1)'(rd_req_len);
    assign w_wr_end   = {1'b0, w_wr_idx} + (IW+1)'(wr_req_len);
    assign w_rd_bad   = (rd_req_addr[1:0] != 2'b00) || w_rd_end[IW];
    assign w_wr_bad   = (wr_req_addr[1:0] != 2'b00) || w_wr_end[IW];
    assign w_beat_bad = w_wr_beat && (wr_last != w_cnt_done);
    assign err        = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if ((w_rd_acc && w_rd_bad) || (w_wr_acc && w_wr_bad) || w_beat_bad) begin
            r_err <= 1'b1;
        end
    end

    assign w_unused = ^{rd_req_addr[31:IW+2], wr_req_addr[31:IW+2]};
`else
    assign w_unused = ^{rd_req_addr[31:IW+2], rd_req_addr[1:0],
                        wr_req_addr[31:IW+2], wr_req_addr[1:0], wr_last};
`endif

endmodule

// File: tb/tb_dma_mem_responder.sv
// Self-checking bench for dma_mem_responder: vector table, hand-written corner sequences, random bursts vs a word-array model.
module tb_dma_mem_responder;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   rd_req_addr = '0;
    logic [4:0]    rd_req_len = '0;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [DW-1:0] rd_rdata;
    logic          rd_valid;
    logic          rd_last;
    logic          rd_ready = 1'b0;
    logic [31:0]   wr_req_addr = '0;
    logic [4:0]    wr_req_len = '0;
    logic          wr_req_valid = 1'b0;
    logic          wr_req_ready;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          wr_last = 1'b0;
`ifdef DMA_MEM_RESP_ERR_EN
    logic          err;
`endif

    dma_mem_responder #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_addr  (rd_req_addr),
        .rd_req_len   (rd_req_len),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_rdata     (rd_rdata),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last),
        .rd_ready     (rd_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_len   (wr_req_len),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
`ifdef DMA_MEM_RESP_ERR_EN
        .wr_last      (wr_last),
        .err          (err)
`else
        .wr_last      (wr_last)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [4:0]  len;
        logic [31:0] d0;
        logic [31:0] step;
        bit          exp_err;
    } vec_t;

    vec_t tbl [7];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic int widx(input logic [31:0] addr, input int beat);
        return int'(((addr >> 2) + 32'(beat)) % DEPTH);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // last_at < 0 gives a correct wr_last; otherwise wr_last is raised on beat last_at.
    task automatic do_write(input logic [31:0] addr, input logic [4:0] len, input logic [31:0] d0,
                            input logic [31:0] step, input int last_at, input bit gaps);
        int n;
        int guard;
        @(negedge clk);
        wr_req_addr  = addr;
        wr_req_len   = len;
        wr_req_valid = 1'b1;
        #1;
        guard = 0;
        while (!wr_req_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("wr_req_ready", 32'(wr_req_ready), 32'd1);
        @(negedge clk);
        wr_req_valid = 1'b0;
        n = 0;
        guard = 0;
        while (n <= int'(len) && guard < 300) begin
            chk("wr_ready_in_burst", 32'(wr_ready), 32'd1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0;
            end else begin
                wr_valid = 1'b1;
                wr_data  = d0 + step * 32'(n);
                wr_last  = (last_at < 0) ? (n == int'(len)) : (n == last_at);
                ref_mem[widx(addr, n)] = d0 + step * 32'(n);
                n++;
            end
            @(negedge clk);
            guard++;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        chk("wr_beats", 32'(n), 32'(int'(len) + 1));
        chk("wr_ready_after", 32'(wr_ready), 32'd0);
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random.
    task automatic do_read(input logic [31:0] addr, input logic [4:0] len, input int mode,
                           input bit use_exp, input logic [31:0] d0, input logic [31:0] step);
        int beat;
        int cyc;
        int guard;
        logic [31:0] exp;
        @(negedge clk);
        rd_ready     = 1'b0;
        rd_req_addr  = addr;
        rd_req_len   = len;
        rd_req_valid = 1'b1;
        #1;
        guard = 0;
        while (!rd_req_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("rd_req_ready", 32'(rd_req_ready), 32'd1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        chk("rd_first_latency", 32'(rd_valid), 32'd1);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 300) begin
            exp = use_exp ? (d0 + step * 32'(beat)) : ref_mem[widx(addr, beat)];
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_rdata", rd_rdata, exp);
            chk("rd_last", 32'(rd_last), 32'(beat == int'(len)));
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (rd_ready) beat++;
            @(negedge clk);
            cyc++;
        end
        rd_ready = 1'b0;
        chk("rd_beats", 32'(beat), 32'(int'(len) + 1));
        chk("rd_valid_after", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [4:0]  l;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        tbl[0] = '{1'b1, 32'h100, 5'd7, 32'h11, 32'h11, 1'b0};
        tbl[1] = '{1'b0, 32'h100, 5'd7, 32'h11, 32'h11, 1'b0};
        tbl[2] = '{1'b1, 32'h200, 5'd0, 32'h5A, 32'h0,  1'b0};
        tbl[3] = '{1'b1, 32'hFF8, 5'd3, 32'hA0, 32'h1,  1'b1};
        tbl[4] = '{1'b0, 32'hFF8, 5'd3, 32'hA0, 32'h1,  1'b1};
        tbl[5] = '{1'b0, 32'h000, 5'd1, 32'hA2, 32'h1,  1'b1};
        tbl[6] = '{1'b0, 32'h203, 5'd0, 32'h5A, 32'h0,  1'b1};

        // Reset state
        #12;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        chk("rst_rd_rdata", rd_rdata, 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_req_ready", 32'(rd_req_ready), 32'd0);
        chk("rst_wr_req_ready", 32'(wr_req_ready), 32'd0);
`ifdef DMA_MEM_RESP_ERR_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Arbitration: read first after reset, then write, then read again
        @(negedge clk);
        rd_req_addr = 32'h100; rd_req_len = 5'd0; rd_req_valid = 1'b1;
        wr_req_addr = 32'h300; wr_req_len = 5'd0; wr_req_valid = 1'b1;
        rd_ready = 1'b1;
        #1;
        chk("arb1_rd_req_ready", 32'(rd_req_ready), 32'd1);
        chk("arb1_wr_req_ready", 32'(wr_req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("arb_busy_rd_valid", 32'(rd_valid), 32'd1);
        chk("arb_busy_wr_req_ready", 32'(wr_req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("arb2_wr_req_ready", 32'(wr_req_ready), 32'd1);
        chk("arb2_rd_req_ready", 32'(rd_req_ready), 32'd0);
        @(negedge clk);
        rd_req_valid = 1'b0; wr_req_valid = 1'b0; rd_ready = 1'b0;
        chk("arb_wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1; wr_data = 32'h77; wr_last = 1'b1;
        ref_mem[widx(32'h300, 0)] = 32'h77;
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0;
        rd_req_valid = 1'b1; wr_req_valid = 1'b1;
        #1;
        chk("arb3_rd_req_ready", 32'(rd_req_ready), 32'd1);
        chk("arb3_wr_req_ready", 32'(wr_req_ready), 32'd0);
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        do_read(32'h300, 5'd0, 0, 1'b0, 32'h0, 32'h0);

        // Vector table
        apply_reset();
        foreach (tbl[i]) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].len, tbl[i].d0, tbl[i].step, -1, 1'b0);
            else           do_read(tbl[i].addr, tbl[i].len, 0, 1'b1, tbl[i].d0, tbl[i].step);
`ifdef DMA_MEM_RESP_ERR_EN
            chk("tbl_err", 32'(err), 32'(tbl[i].exp_err));
`endif
        end

        // Read len 3 with ready toggling 1,0,0,1
        do_read(32'h100, 5'd3, 1, 1'b1, 32'h11, 32'h11);

        // Reset while beat 2 of a read burst is presented
        @(negedge clk);
        rd_req_addr = 32'h100; rd_req_len = 5'd7; rd_req_valid = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(rd_req_ready), 32'd1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_beat2", rd_rdata, 32'h33);
        rd_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_rd_last", 32'(rd_last), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_read(32'h100, 5'd7, 0, 1'b1, 32'h11, 32'h11);

`ifdef DMA_MEM_RESP_ERR_EN
        apply_reset();
        do_write(32'hFF8, 5'd3, 32'hC0, 32'h1, -1, 1'b0);
        chk("err_wrap", 32'(err), 32'd1);
        apply_reset();
        chk("err_cleared", 32'(err), 32'd0);
        do_write(32'h500, 5'd7, 32'hD0, 32'h1, 5, 1'b0);
        chk("err_wr_last", 32'(err), 32'd1);
        apply_reset();
        do_write(32'h500, 5'd7, 32'hE0, 32'h1, -1, 1'b0);
        do_read(32'h500, 5'd7, 0, 1'b1, 32'hE0, 32'h1);
        chk("err_clean", 32'(err), 32'd0);
        do_read(32'h502, 5'd0, 0, 1'b1, 32'hE0, 32'h0);
        chk("err_unaligned", 32'(err), 32'd1);
`endif

        // Random bursts against the word-array model; fill the array first
        for (int k = 0; k < DEPTH / 32; k++) begin
            do_write(32'(k * 128), 5'd31, $urandom, $urandom, -1, 1'b0);
        end
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            l = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) do_write(a, l, $urandom, $urandom, -1, 1'b1);
            else                           do_read(a, l, 2, 1'b0, 32'h0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
